kugelblitz_capture: RTL and testbench
=====================================

Name: kugelblitz_capture

Overview:
- Inline AXI-stream tap on a kugelblitz port datapath; the read-side counterpart of the byte-patching offload.
- Passes frames through unmodified.
- Extracts a 32-bit field at a software-programmed byte offset from each frame and exposes it over an AXI-lite slave with valid/overflow status and a frame counter.
- One instance per port per direction (tx or rx).

Parameters:
- AXIS_DATA_WIDTH, 512, stream data width; only 512 is legal (elaboration error otherwise).
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 1, tuser width, passed through.
- AXIL_DATA_WIDTH, 32, AXI-lite data width; only 32 is legal.
- AXIL_ADDR_WIDTH, 32, AXI-lite address width.
- AXIL_STRB_WIDTH, AXIL_DATA_WIDTH/8, write strobe width.

Ports:
- clk in 1: single clock for stream and AXI-lite.
- rst_n in 1: asynchronous, active-low reset.
- s_axis_tdata/tkeep/tvalid/tlast/tuser: in; widths AXIS_DATA_WIDTH/AXIS_KEEP_WIDTH/1/1/USER_WIDTH; upstream stream.
- s_axis_tready out 1.
- m_axis_tdata/tkeep/tvalid/tlast/tuser: out; same widths; downstream stream.
- m_axis_tready in 1.
- s_axil_awaddr in AXIL_ADDR_WIDTH; awprot in 3; awvalid in 1; awready out 1.
- s_axil_wdata in 32; wstrb in 4; wvalid in 1; wready out 1.
- s_axil_bresp out 2; bvalid out 1; bready in 1.
- s_axil_araddr in AXIL_ADDR_WIDTH; arprot in 3; arvalid in 1; arready out 1.
- s_axil_rdata out 32; rresp out 2; rvalid out 1; rready in 1.

Behaviour:
- Stream is combinational passthrough: m_* = s_*, s_axis_tready = m_axis_tready. Zero latency, no modification.
- Beat is accepted when s_axis_tvalid & m_axis_tready. Beat counter (12 bit) resets to 0 after a tlast beat and saturates at 4095.
- Register map (addr[4:2]):
  - 0x00 CTRL: bit0 enable; RW; reset 0.
  - 0x04 OFFSET: [11:0] byte offset; RW; reset 0.
  - 0x08 DATA: captured word; RO. A read clears STATUS.valid.
  - 0x0C STATUS: bit0 valid, bit1 overflow, bit2 short; RO. Read clears bits 1 and 2.
  - 0x10 FRAME_CNT: 32-bit count of tlast beats seen; wraps; counts regardless of enable; RW (any write clears it to 0).
  - Others: read 0, writes ignored, resp OKAY.
- OFFSET and enable are latched at the first beat of each frame. Mid-frame changes take effect on the next frame.
- Capture: byte j (0..3) comes from beat (O+j)>>6, lane (O+j)&63, and is placed at bits [8j+7:8j] (little-endian). A byte counts only if its tkeep lane is 1. Fields may straddle two beats.
- Commit at the tlast beat, only if enabled and all 4 bytes were captured:
  - DATA <= field; valid <= 1.
  - overflow <= 1 if valid was already 1 and is not being cleared in that cycle.
- If enabled but fewer than 4 bytes were captured (short frame or tkeep hole): no commit; short <= 1.
- Simultaneous DATA read and commit: read returns old DATA, valid ends at 1 with new DATA, overflow not set.
- AXI-lite write:
  - awready = wready = 1 in the cycle both awvalid & wvalid are high and bvalid = 0.
  - bvalid asserts the next cycle, bresp = 0, held until bready.
  - wstrb honoured per byte.
- AXI-lite read:
  - arready = !rvalid.
  - rvalid the next cycle with rdata registered, held until rready.
- Reset (rst_n low, async) sets all registers, counters, bvalid, rvalid, awready, wready, arready, rdata, bresp and rresp to 0.
- Reset mid-frame discards the partial capture. The next accepted beat is treated as a frame start.

Optional Feature:
- KG_CAPTURE_MATCH_EN defined:
  - Adds register 0x14 MATCH: [15:0] ethertype, bit16 match_enable; RW; reset 0.
  - When match_enable = 1, commit additionally requires frame bytes 12..13 (big-endian, beat 0) to equal MATCH[15:0].
  - Non-matching frames neither commit nor set short.
- Undefined: 0x14 reads 0, and every enabled complete frame commits.

Test Plan:
- enable=1, OFFSET=16, one 64-byte frame with byte n = n -> DATA=0x13121110, STATUS=0x1, FRAME_CNT=1; a subsequent DATA read makes STATUS=0x0.
- OFFSET=62, 128-byte frame with byte n = n (straddling two beats) -> DATA=0x41403F3E.
- OFFSET=60, 62-byte frame -> no commit, STATUS.short=1, valid=0.
- Two frames at OFFSET=0 without reading -> DATA holds the second frame's field, STATUS=0x3.
- m_axis_tready toggling 50% during a 3-beat frame -> output identical to input every cycle, FRAME_CNT increments by 1 only on the accepted tlast beat.
- With KG_CAPTURE_MATCH_EN, MATCH=0x10800: frame ethertype 0x0800 commits; frame ethertype 0x86DD leaves valid=0 and short=0.

Source files
------------

// File: rtl/kugelblitz_capture.sv
// kugelblitz_capture
// Inline AXI-stream tap. Frames pass straight through with zero latency; a
// 32-bit little-endian field at a programmable byte offset is captured from
// each frame and exposed through an AXI-lite register block.
//
// Ports
//   clk, rst_n        : single clock, asynchronous active-low reset
//   s_axis_*          : upstream stream (tdata/tkeep/tvalid/tready/tlast/tuser)
//   m_axis_*          : downstream stream, combinational copy of s_axis_*
//   s_axil_*          : AXI-lite slave (aw/w/b/ar/r channels)
//
// Register map (addr[4:2])
//   0x00 CTRL      bit0 enable                        RW
//   0x04 OFFSET    [11:0] byte offset of the field    RW
//   0x08 DATA      captured word, read clears valid   RO
//   0x0C STATUS    {short, overflow, valid}, read clears short/overflow
//   0x10 FRAME_CNT count of tlast beats, any write clears
//   0x14 MATCH     [15:0] ethertype, bit16 match_enable (KG_CAPTURE_MATCH_EN)
//
// Build option: define KG_CAPTURE_MATCH_EN to add the ethertype filter.
// Without it 0x14 reads 0 and every enabled complete frame commits.

module kugelblitz_capture #(
   parameter int AXIS_DATA_WIDTH = 512,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
   parameter int USER_WIDTH      = 1,
   parameter int AXIL_DATA_WIDTH = 32,
   parameter int AXIL_ADDR_WIDTH = 32,
   parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH/8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   input  logic [USER_WIDTH-1:0]      s_axis_tuser,
   output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic [USER_WIDTH-1:0]      m_axis_tuser,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [2:0]                 s_axil_awprot,
   input  logic                       s_axil_awvalid,
   output logic                       s_axil_awready,
   input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                       s_axil_wvalid,
   output logic                       s_axil_wready,
   output logic [1:0]                 s_axil_bresp,
   output logic                       s_axil_bvalid,
   input  logic                       s_axil_bready,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]                 s_axil_arprot,
   input  logic                       s_axil_arvalid,
   output logic                       s_axil_arready,
   output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]                 s_axil_rresp,
   output logic                       s_axil_rvalid,
   input  logic                       s_axil_rready
);

   if (AXIS_DATA_WIDTH != 512) begin : g_bad_axis_width
      $error("kugelblitz_capture: AXIS_DATA_WIDTH must be 512");
   end
   if (AXIL_DATA_WIDTH != 32) begin : g_bad_axil_width
      $error("kugelblitz_capture: AXIL_DATA_WIDTH must be 32");
   end

   // Stream passthrough
   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tkeep  = s_axis_tkeep;
   assign m_axis_tvalid = s_axis_tvalid;
   assign m_axis_tlast  = s_axis_tlast;
   assign m_axis_tuser  = s_axis_tuser;
   assign s_axis_tready = m_axis_tready;

   wire beat = s_axis_tvalid & m_axis_tready;

   // Registers and frame state
   logic        ctrl_en;
   logic [11:0] offset_reg;
   logic [31:0] data_reg;
   logic        valid, overflow, short_flag;
   logic [31:0] frame_cnt;
   logic [11:0] beat_cnt;       // beat index within the current frame
   logic [3:0]  got_acc;        // field bytes captured on earlier beats
   logic [31:0] field_acc;
   logic        fr_en;
   logic [11:0] fr_off;
   logic        ready_en;       // holds the AXI-lite readies low until out of reset

   // A zero beat counter marks a frame start; there the live register values
   // apply, on later beats the values latched at the start apply.
   wire        frame_start = (beat_cnt == 12'd0);
   wire        eff_en      = frame_start ? ctrl_en    : fr_en;
   wire [11:0] eff_off     = frame_start ? offset_reg : fr_off;
   logic       eff_match;

`ifdef KG_CAPTURE_MATCH_EN
   logic [16:0] match_reg;
   logic        fr_match;
   // Ethertype is bytes 12..13 of beat 0, transmitted big-endian.
   wire  [15:0] ethertype = {s_axis_tdata[103:96], s_axis_tdata[111:104]};
   assign eff_match = frame_start ? (!match_reg[16] || ethertype == match_reg[15:0]) : fr_match;
`else
   assign eff_match = 1'b1;
`endif

   // Field byte selection for the current beat
   logic [3:0]  got_now;
   logic [31:0] field_now;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      got_now   = got_acc;
      field_now = field_acc;
      for (int j = 0; j < 4; j++) begin
         logic [12:0] pos;
         pos = {1'b0, eff_off} + 13'(j);
         if (beat_cnt == {5'd0, pos[12:6]} && s_axis_tkeep[pos[5:0]]) begin
            got_now[j]         = 1'b1;
            field_now[8*j +: 8] = s_axis_tdata[{pos[5:0], 3'b000} +: 8];
         end
      end
   end

   wire frame_end = beat & s_axis_tlast;
   wire commit    = frame_end & eff_en & eff_match & (&got_now);
   wire short_evt = frame_end & eff_en & eff_match & ~(&got_now);

   // AXI-lite handshakes
   assign s_axil_awready = ready_en & s_axil_awvalid & s_axil_wvalid & ~s_axil_bvalid;
   assign s_axil_wready  = s_axil_awready;
   assign s_axil_arready = ready_en & ~s_axil_rvalid;
   assign s_axil_bresp   = 2'b00;
   assign s_axil_rresp   = 2'b00;

   wire       wr_hs   = s_axil_awready;
   wire       rd_hs   = s_axil_arvalid & s_axil_arready;
   wire [2:0] wr_sel  = s_axil_awaddr[4:2];
   wire [2:0] rd_sel  = s_axil_araddr[4:2];
   wire       rd_data_clr   = rd_hs && rd_sel == 3'd2;
   wire       rd_status_clr = rd_hs && rd_sel == 3'd3;

   wire unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr, s_axil_wdata, s_axil_wstrb};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt  <= '0;
         got_acc   <= '0;
         field_acc <= '0;
         fr_en     <= 1'b0;
         fr_off    <= '0;
`ifdef KG_CAPTURE_MATCH_EN
         fr_match  <= 1'b0;
`endif
      end else if (beat) begin
         if (s_axis_tlast) begin
            beat_cnt <= '0;
            got_acc  <= '0;
         end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (beat_cnt != 12'hFFF) beat_cnt <= beat_cnt + 12'd1;
            got_acc   <= got_now;
            field_acc <= field_now;
            // Reloading mid-frame is harmless: eff_* already equals the latched values.
            fr_en     <= eff_en;
            fr_off    <= eff_off;
`ifdef KG_CAPTURE_MATCH_EN
            fr_match  <= eff_match;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg   <= '0;
         valid      <= 1'b0;
         overflow   <= 1'b0;
         short_flag <= 1'b0;
      end else begin
         if (rd_status_clr) begin
            overflow   <= 1'b0;
            short_flag <= 1'b0;
         end
         if (commit) begin
            data_reg <= field_now;
            valid    <= 1'b1;
            // A DATA read in the same cycle consumes the old word, so no loss.
            if (valid && !rd_data_clr) overflow <= 1'b1;
         end else if (rd_data_clr) begin
            valid <= 1'b0;
         end
         if (short_evt) short_flag <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_en    <= 1'b0;
         offset_reg <= '0;
         frame_cnt  <= '0;
`ifdef KG_CAPTURE_MATCH_EN
         match_reg  <= '0;
`endif
      end else begin
         if (wr_hs && wr_sel == 3'd4)  frame_cnt <= '0;
         else if (frame_end)           frame_cnt <= frame_cnt + 32'd1;
         if (wr_hs) begin
            case (wr_sel)
               3'd0: if (s_axil_wstrb[0]) ctrl_en <= s_axil_wdata[0];
               3'd1: begin
                  if (s_axil_wstrb[0]) offset_reg[7:0]  <= s_axil_wdata[7:0];
                  if (s_axil_wstrb[1]) offset_reg[11:8] <= s_axil_wdata[11:8];
               end
`ifdef KG_CAPTURE_MATCH_EN
               3'd5: begin
                  if (s_axil_wstrb[0]) match_reg[7:0]  <= s_axil_wdata[7:0];
                  if (s_axil_wstrb[1]) match_reg[15:8] <= s_axil_wdata[15:8];
                  if (s_axil_wstrb[2]) match_reg[16]   <= s_axil_wdata[16];
               end
`endif
               default: ;
            endcase
         end
      end
   end

   logic [31:0] rd_mux;
   always_comb begin
      rd_mux = '0;
      case (rd_sel)
         3'd0: rd_mux = {31'd0, ctrl_en};
         3'd1: rd_mux = {20'd0, offset_reg};
         3'd2: rd_mux = data_reg;
         3'd3: rd_mux = {29'd0, short_flag, overflow, valid};
         3'd4: rd_mux = frame_cnt;
`ifdef KG_CAPTURE_MATCH_EN
         3'd5: rd_mux = {15'd0, match_reg};
`endif
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en      <= 1'b0;
         s_axil_bvalid <= 1'b0;
         s_axil_rvalid <= 1'b0;
         s_axil_rdata  <= '0;
      end else begin
         ready_en <= 1'b1;
         if (wr_hs)              s_axil_bvalid <= 1'b1;
         else if (s_axil_bready) s_axil_bvalid <= 1'b0;
         if (rd_hs) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_mux;
         end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kugelblitz_capture.sv
// Self-checking bench for kugelblitz_capture. Frames are described as byte
// arrays with per-byte keep flags; a byte-level model derives the captured
// field, status flags and frame count from them.
module tb_kugelblitz_capture;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [511:0] s_axis_tdata = '0;
   logic [63:0]  s_axis_tkeep = '0;
   logic         s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
   logic [0:0]   s_axis_tuser = '0;
   logic         s_axis_tready;
   logic [511:0] m_axis_tdata;
   logic [63:0]  m_axis_tkeep;
   logic         m_axis_tvalid, m_axis_tlast;
   logic [0:0]   m_axis_tuser;
   logic         m_axis_tready = 1'b1;
   logic [31:0]  awaddr = '0, wdata = '0, araddr = '0, rdata;
   logic [3:0]   wstrb = '0;
   logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
   logic         awready, wready, arready, bvalid, rvalid;
   logic         bready = 1'b1, rready = 1'b1;
   logic [1:0]   bresp, rresp;

   kugelblitz_capture dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
      .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
      .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
      .s_axil_araddr(araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
      .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
   );

   int n_checks = 0, n_pass = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   bit          m_ctrl, m_valid, m_ovf, m_short;
   logic [11:0] m_off;
   logic [31:0] m_data, m_fcnt;
   logic [16:0] m_match;
   logic [7:0]  fb [0:1023];
   bit          fk [0:1023];
   int          f_beats;

   task automatic model_reset();
      m_ctrl = 0; m_valid = 0; m_ovf = 0; m_short = 0;
      m_off = '0; m_data = '0; m_fcnt = '0; m_match = '0;
   endtask

   task automatic fill_frame(input int nbytes, input bit incr, input bit hole);
      f_beats = (nbytes + 63) / 64;
      for (int i = 0; i < f_beats * 64; i++) begin
         fb[i] = incr ? 8'(i) : 8'($urandom);
         fk[i] = (i < nbytes);
      end
      if (hole) fk[$urandom_range(0, nbytes - 1)] = 0;
   endtask

   // Expected effect of one complete frame on the register state.
   task automatic model_frame();
      logic [31:0] f;
      bit ok;
      m_fcnt++;
      if (!m_ctrl) return;
      if (m_match[16] && {fb[12], fb[13]} != m_match[15:0]) return;
      ok = 1;
      f = '0;
      for (int j = 0; j < 4; j++) begin
         int p;
         p = int'(m_off) + j;
         if (p < f_beats * 64 && fk[p]) f[8*j +: 8] = fb[p];
         else ok = 0;
      end
      if (ok) begin
         if (m_valid) m_ovf = 1;
         m_valid = 1;
         m_data = f;
      end else begin
         m_short = 1;
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      case (a[4:2])
         3'd0: return {31'd0, m_ctrl};
         3'd1: return {20'd0, m_off};
         3'd2: return m_data;
         3'd3: return {29'd0, m_short, m_ovf, m_valid};
         3'd4: return m_fcnt;
`ifdef KG_CAPTURE_MATCH_EN
         3'd5: return {15'd0, m_match};
`endif
         default: return 32'd0;
      endcase
   endfunction

   // All tasks start and end just after a rising edge.
   task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
      n = 0;
      while (!awready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) check("aw_timeout", 0, 1);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      check("bvalid", {bvalid, bresp}, 3'b100);
      @(posedge clk); #1;
      case (a[4:2])
         3'd0: if (s[0]) m_ctrl = d[0];
         3'd1: begin
            if (s[0]) m_off[7:0] = d[7:0];
            if (s[1]) m_off[11:8] = d[11:8];
         end
         3'd4: m_fcnt = '0;
`ifdef KG_CAPTURE_MATCH_EN
         3'd5: begin
            if (s[0]) m_match[7:0] = d[7:0];
            if (s[1]) m_match[15:8] = d[15:8];
            if (s[2]) m_match[16] = d[16];
         end
`endif
         default: ;
      endcase
   endtask

   task automatic reg_check(input logic [31:0] a, input string tag);
      int n;
      logic [31:0] exp;
      araddr = a; arvalid = 1;
      n = 0;
      while (!arready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) check("ar_timeout", 0, 1);
      @(posedge clk); #1;
      arvalid = 0;
      exp = model_read(a);
      check({tag, "_rvalid"}, {rvalid, rresp}, 3'b100);
      check(tag, rdata, exp);
      if (a[4:2] == 3'd2) m_valid = 0;
      if (a[4:2] == 3'd3) begin m_ovf = 0; m_short = 0; end
      @(posedge clk); #1;
   endtask

   task automatic drive_beat(input int b);
      for (int i = 0; i < 64; i++) begin
         s_axis_tdata[8*i +: 8] = fb[b*64 + i];
         s_axis_tkeep[i] = fk[b*64 + i];
      end
      s_axis_tlast = (b == f_beats - 1);
      s_axis_tuser = 1'($urandom);
      s_axis_tvalid = 1;
   endtask

   task automatic send_frame(input bit toggle);
      for (int b = 0; b < f_beats; b++) begin
         bit acc;
         int n;
         drive_beat(b);
         acc = 0; n = 0;
         while (!acc && n < 100) begin
            m_axis_tready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("passthrough", (m_axis_tdata === s_axis_tdata) && (m_axis_tkeep === s_axis_tkeep) &&
                  (m_axis_tvalid === s_axis_tvalid) && (m_axis_tlast === s_axis_tlast) &&
                  (m_axis_tuser === s_axis_tuser), 1);
            check("tready", s_axis_tready, m_axis_tready);
            acc = m_axis_tready;
            @(posedge clk); #1;
            n++;
         end
         if (!acc) check("stream_timeout", 0, 1);
      end
      s_axis_tvalid = 0; s_axis_tlast = 0; m_axis_tready = 1;
      model_frame();
   endtask

   task automatic check_all(input string tag);
      reg_check(32'h0C, {tag, "_status"});
      reg_check(32'h08, {tag, "_data"});
      reg_check(32'h10, {tag, "_fcnt"});
   endtask

   initial begin
      logic [31:0] old;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
      check("reset_bvalid_rvalid", {bvalid, rvalid, rdata}, 34'd0);
      for (int a = 0; a < 8; a++) reg_check(32'(a * 4), "reset_reg");

      // Basic capture at offset 16
      axil_write(32'h00, 32'h1, 4'hF);
      axil_write(32'h04, 32'd16, 4'hF);
      fill_frame(64, 1, 0);
      send_frame(0);
      reg_check(32'h0C, "tp1_status");
      reg_check(32'h10, "tp1_fcnt");
      check("tp1_const", m_data, 32'h13121110);
      reg_check(32'h08, "tp1_data");
      reg_check(32'h0C, "tp1_status_after");

      // Field straddling two beats
      axil_write(32'h04, 32'd62, 4'hF);
      fill_frame(128, 1, 0);
      send_frame(0);
      check("tp2_const", m_data, 32'h41403F3E);
      check_all("tp2");

      // Short frame
      axil_write(32'h04, 32'd60, 4'hF);
      fill_frame(62, 1, 0);
      send_frame(0);
      reg_check(32'h0C, "tp3_status");

      // Overflow: two frames without reading
      axil_write(32'h04, 32'd0, 4'hF);
      fill_frame(64, 0, 0); send_frame(0);
      fill_frame(70, 0, 0); send_frame(0);
      reg_check(32'h0C, "tp4_status");
      reg_check(32'h08, "tp4_data");

      // Backpressure on a 3-beat frame
      axil_write(32'h04, 32'd130, 4'hF);
      fill_frame(192, 0, 0);
      send_frame(1);
      check_all("tp5");

      // Partial strobe: only the upper offset byte is written
      axil_write(32'h04, 32'h0000_0ABC, 4'b0010);
      reg_check(32'h04, "wstrb_offset");

      // Randomized frames, offsets near beat edges, occasional keep holes
      for (int k = 0; k < 24; k++) begin
         int nb, off;
         axil_write(32'h00, 32'($urandom_range(0, 3) != 0), 4'hF);
         off = ($urandom_range(0, 1) != 0) ? $urandom_range(56, 72) : $urandom_range(0, 260);
         axil_write(32'h04, 32'(off), 4'h3);
         nb = $urandom_range(1, 320);
         fill_frame(nb, 0, $urandom_range(0, 3) == 0);
         send_frame($urandom_range(0, 1) != 0);
         if ($urandom_range(0, 2) == 0) check_all("rand");
         else reg_check(32'h0C, "rand_status");
      end
      check_all("rand_final");

      // DATA read in the same cycle as a commit
      axil_write(32'h00, 32'h1, 4'hF);
      axil_write(32'h04, 32'd8, 4'hF);
      fill_frame(64, 0, 0); send_frame(0);
      reg_check(32'h0C, "pre_sim_status");
      fill_frame(64, 0, 0);
      old = m_data;
      drive_beat(0);
      araddr = 32'h08; arvalid = 1;
      #1 check("sim_arready", arready, 1);
      @(posedge clk); #1;
      s_axis_tvalid = 0; s_axis_tlast = 0; arvalid = 0;
      check("sim_rdata", {rvalid, rdata}, {1'b1, old});
      @(posedge clk); #1;
      m_valid = 0;
      model_frame();
      check_all("sim");

      // FRAME_CNT clears on any write
      axil_write(32'h10, 32'hFFFF_FFFF, 4'h0);
      reg_check(32'h10, "fcnt_clear");

      // Unmapped register writes are ignored
      axil_write(32'h18, 32'hFFFF_FFFF, 4'hF);
      reg_check(32'h18, "unmapped");

`ifdef KG_CAPTURE_MATCH_EN
      axil_write(32'h14, 32'h0001_0800, 4'hF);
      reg_check(32'h14, "match_reg");
      axil_write(32'h04, 32'd20, 4'hF);
      fill_frame(64, 0, 0); fb[12] = 8'h08; fb[13] = 8'h00;
      send_frame(0);
      check_all("match_hit");
      fill_frame(64, 0, 0); fb[12] = 8'h86; fb[13] = 8'hDD;
      send_frame(0);
      reg_check(32'h0C, "match_miss_status");
`else
      axil_write(32'h14, 32'h0001_0800, 4'hF);
      reg_check(32'h14, "match_absent");
`endif

      // Reset in the middle of a frame
      axil_write(32'h04, 32'd70, 4'hF);
      fill_frame(128, 0, 0);
      drive_beat(0);
      @(posedge clk); #1;
      s_axis_tvalid = 0; s_axis_tlast = 0;
      rst_n = 0;
      #2 rst_n = 1;
      model_reset();
      @(posedge clk); #1;
      reg_check(32'h00, "rst_ctrl");
      check_all("rst");
      axil_write(32'h00, 32'h1, 4'hF);
      axil_write(32'h04, 32'd4, 4'hF);
      fill_frame(64, 0, 0);
      send_frame(0);
      check_all("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
